// File: rtl/fetch_queue_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Handshake bundle between fetch_queue, instruction memory,
//            the redirect/halt sources and the IF-stage consumer.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          deq;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [CW-1:0] count;

  // master: the queue itself
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, count,
    input  imem_ack, imem_rdata, redirect, redirect_pc, halt, deq
  );

  // slave: memory, pipeline control and consumer side
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, count,
    output imem_ack, imem_rdata, redirect, redirect_pc, halt, deq
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction prefetch queue with req/ack memory fetch, redirect
//            flush and halt; buffers DEPTH {instr, pc} pairs for the IF stage.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_queue_if.master fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_drop = 2'd2;

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] w_fetch_pc_nxt;
  logic [AW-1:0] r_imem_addr;
  logic [AW-1:0] w_imem_addr_nxt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic [IW-1:0] r_mem_instr [DEPTH];
  logic [AW-1:0] r_mem_pc    [DEPTH];

  logic          w_ack;
  logic          w_enq;
  logic          w_deq;
  logic          w_issue;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_after_ack;

  // Ack only means something while a request is actually outstanding
  assign w_ack = fq.imem_ack && (r_state != c_idle);
  assign w_enq = w_ack && (r_state == c_wait) && !fq.redirect;
  assign w_deq = fq.deq && (r_count != '0) && !fq.redirect;

  always_comb begin
    w_count_nxt = r_count;
    if (fq.redirect) begin
      w_count_nxt = '0;
    end else if (w_enq && !w_deq) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_enq && w_deq) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // A new request reserves a slot that is guaranteed free when it returns
  assign w_issue     = !fq.halt && (w_count_nxt < c_depth);
  assign w_pc_inc    = r_imem_addr + AW'(1);
  assign w_target    = fq.redirect ? fq.redirect_pc : r_fetch_pc;
  assign w_after_ack = fq.redirect ? fq.redirect_pc : w_pc_inc;

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_imem_addr_nxt = r_imem_addr;
    case (r_state)
      c_idle: begin
        w_fetch_pc_nxt = w_target;
        if (w_issue) begin
          w_state_nxt     = c_wait;
          w_imem_addr_nxt = w_target;
        end
      end
      c_wait: begin
        if (w_ack) begin
          w_fetch_pc_nxt = w_after_ack;
          if (w_issue) begin
            w_state_nxt     = c_wait;
            w_imem_addr_nxt = w_after_ack;
          end else begin
            w_state_nxt = c_idle;
          end
        end else if (fq.redirect) begin
          // Address must stay stable until the in-flight request is acked
          w_state_nxt    = c_drop;
          w_fetch_pc_nxt = fq.redirect_pc;
        end
      end
      c_drop: begin
        w_fetch_pc_nxt = w_target;
        if (w_ack) begin
          if (w_issue) begin
            w_state_nxt     = c_wait;
            w_imem_addr_nxt = w_target;
          end else begin
            w_state_nxt = c_idle;
          end
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_fetch_pc  <= '0;
      r_imem_addr <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_count     <= w_count_nxt;
      if (fq.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset: head outputs are masked by occupancy
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_instr[r_wr_ptr] <= fq.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_imem_addr;
    end
  end

  assign fq.imem_req    = (r_state != c_idle);
  assign fq.imem_addr   = r_imem_addr;
  assign fq.count       = r_count;
  assign fq.instr_valid = (r_count != '0);
  assign fq.instr       = (r_count != '0) ? r_mem_instr[r_rd_ptr] : '0;
  assign fq.instr_pc    = (r_count != '0) ? r_mem_pc[r_rd_ptr]    : '0;

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the IF stage of the 16-bit pipelined CPU. It issues word-addressed fetches to a multi-cycle instruction memory over a req/ack handshake and buffers up to DEPTH instructions with their PCs. The IF stage consumes entries in order. Branch/jump redirects from MEM/EX flush the queue, and halt stops further fetching.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- AW, 16, PC/address width
- IW, 16, instruction width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- imem_req  out  1  fetch request; held high until acked
- imem_addr  out  AW  fetch word address; stable while imem_req=1
- imem_ack  in  1  imem_rdata valid this cycle; ignored when imem_req=0
- imem_rdata  in  IW  fetched instruction
- redirect  in  1  one-cycle pulse: flush queue and restart fetch at redirect_pc
- redirect_pc  in  AW  new fetch address
- halt  in  1  level; while high, no new requests are issued
- deq  in  1  consumer takes head entry this cycle
- instr  out  IW  head instruction; 0 when instr_valid=0
- instr_pc  out  AW  PC of head instruction; 0 when instr_valid=0
- instr_valid  out  1  queue non-empty
- count  out  log2(DEPTH)+1  current occupancy

## Operation
- State: fetch_pc register, circular buffer (rd_ptr, wr_ptr, count), and a 3-state FSM.
  - IDLE: no request outstanding.
  - WAIT: request outstanding; response will be enqueued.
  - DROP: request outstanding; response will be discarded.
- Issue condition: !halt && (count_next + 1 <= DEPTH). count_next is occupancy after this cycle's enqueue/dequeue. A request is never issued unless a free slot is reserved for it, so an enqueue never meets a full queue.
- IDLE → WAIT when the issue condition holds. Next cycle: imem_req=1, imem_addr=fetch_pc.
- WAIT with imem_ack:
  - Write {imem_rdata, imem_addr} at wr_ptr, then fetch_pc = imem_addr + 1 (mod 2^AW; wraps 0xFFFF → 0x0000).
  - If the issue condition holds, stay in WAIT with the new address (back-to-back). Otherwise go to IDLE and drop req.
- Redirect (highest priority):
  - Clears count and both pointers; any simultaneous deq is ignored.
  - fetch_pc = redirect_pc.
  - WAIT without ack → DROP. imem_req stays high with the old address until ack.
  - WAIT with ack, or DROP with ack → the returning data is discarded; go to IDLE, or to WAIT at redirect_pc if the issue condition holds.
  - IDLE → normal issue rules apply from redirect_pc.
- DROP with ack: discard data; go to IDLE or to WAIT at fetch_pc per the issue condition. Redirect in DROP only updates fetch_pc.
- Halt:
  - An outstanding request still completes and enqueues (WAIT) or is discarded (DROP).
  - The queue still drains via deq.
  - Redirect while halted still flushes and updates fetch_pc.
- deq when count=0 is ignored. Simultaneous enqueue and deq keeps count unchanged.

## Timing
- Reset values: imem_req=0, imem_addr=0, fetch_pc=0, FSM=IDLE, count=0, instr_valid=0, instr=0, instr_pc=0.
- After rst deasserts: imem_req=1 with addr 0 on the first edge, if halt=0.
- Ack latency:
  - Ack sampled at edge N → entry visible (instr_valid, instr, instr_pc) after edge N.
  - count updates at the same edge.
- Head outputs are combinational from buffer[rd_ptr]; deq at edge N shows the next entry after N.
- Peak throughput: one instruction per cycle with single-cycle ack and continuous deq.
- Redirect at edge N: instr_valid=0 after N. The first redirected request is visible after N if IDLE, or after the pending ack if WAIT.
- rst mid-transaction: every register returns to its reset value immediately. A later ack with imem_req=0 is ignored.

## Test plan
- Reset release, halt=0, memory acks every cycle returning data = 0x1000 + addr, no deq → requests at 0, 1, 2, 3. Then count=4 and imem_req=0. Head is instr=0x1000, instr_pc=0.
- Same setup with deq held high → continuous stream with instr_pc = 0, 1, 2, …, one per cycle. count stays ≤ 1 after startup.
- Ack delayed 3 cycles; redirect to 0x0040 during WAIT → imem_addr stays at the old address until ack, and that data is not enqueued. Next request is 0x0040; first dequeued instr_pc = 0x0040.
- Redirect coincident with ack and deq while count=2 → count=0 next cycle and the acked data is discarded. Next request is redirect_pc.
- halt asserted while WAIT → the pending instruction is enqueued and no further request is issued. Deasserting halt resumes at the last PC + 1.
- redirect_pc=0xFFFE with continuous acks → enqueued PCs are 0xFFFE, 0xFFFF, 0x0000.
